// File: rtl/pause_dim_ctrl.sv
// Merges user, OSD and external pause sources into one registered pause line and fades the
// video output in steps while the user pause is held.
module pause_dim_ctrl #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned COLW       = 4,
  parameter int unsigned DIM_TICKS  = 400_000_000,
  parameter int unsigned STEP_TICKS = 20_000_000,
  parameter int unsigned DIM_MAX    = 1,
  parameter int unsigned SYNC_VBL   = 0,
  parameter int unsigned CNTW       = 32,
  localparam int unsigned DLW       = $clog2(COLW + 1)
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pause_btn,
  input  logic [NREQ-1:0]   pause_req,
  input  logic              osd_open,
  input  logic              osd_pause_en,
  input  logic              vblank,
  input  logic [3*COLW-1:0] rgb_in,
  output logic              pause,
  output logic              user_paused,
  output logic [DLW-1:0]    dim_level,
  output logic [3*COLW-1:0] rgb_out
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StFade = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  localparam logic [CNTW-1:0] DimLast  = CNTW'(DIM_TICKS - 1);
  localparam logic [CNTW-1:0] StepLast = CNTW'(STEP_TICKS - 1);
  localparam logic [DLW-1:0]  DimMax   = DLW'(DIM_MAX);
  localparam logic [DLW-1:0]  DimOne   = DLW'(1);

  logic            btn_q, vbl_q, pause_s_q, pause_s_d;
  logic            sync_src, vbl_rise, user_paused_d;
  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] timer_q, timer_d;
  logic [DLW-1:0]  dim_d, dim_inc;
  logic [3*COLW-1:0] rgb_d;

  always_comb begin
    user_paused_d = user_paused ^ (pause_btn & ~btn_q);
    sync_src      = user_paused | (osd_open & osd_pause_en);
    vbl_rise      = vblank & ~vbl_q;
    pause_s_d     = ((SYNC_VBL == 0) || vbl_rise) ? sync_src : pause_s_q;
  end

  // The IDLE->WAIT edge counts as the first tick so dim_level lands exactly DIM_TICKS
  // cycles after user_paused rises.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dim_d   = dim_level;
    dim_inc = dim_level + DimOne;
    if (!user_paused) begin
      state_d = StIdle;
      timer_d = '0;
      dim_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (DIM_TICKS == 1) begin
            dim_d   = DimOne;
            timer_d = '0;
            state_d = (DIM_MAX == 1) ? StHold : StFade;
          end else begin
            timer_d = CNTW'(1);
            state_d = StWait;
          end
        end
        StWait: begin
          if (timer_q == DimLast) begin
            dim_d   = DimOne;
            timer_d = '0;
            state_d = (DIM_MAX == 1) ? StHold : StFade;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StFade: begin
          if (timer_q == StepLast) begin
            dim_d   = dim_inc;
            timer_d = '0;
            if (dim_inc >= DimMax) state_d = StHold;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StHold: ;
        default: begin
          state_d = StIdle;
          timer_d = '0;
          dim_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    rgb_d = '0;
    for (int i = 0; i < 3; i++) begin
      rgb_d[i*COLW +: COLW] = rgb_in[i*COLW +: COLW] >> dim_level;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_q       <= 1'b1;
      vbl_q       <= 1'b1;
      pause_s_q   <= 1'b0;
      pause       <= 1'b0;
      user_paused <= 1'b0;
      state_q     <= StIdle;
      timer_q     <= '0;
      dim_level   <= '0;
      rgb_out     <= '0;
    end else begin
      btn_q       <= pause_btn;
      vbl_q       <= vblank;
      pause_s_q   <= pause_s_d;
      pause       <= (|pause_req) | pause_s_d;
      user_paused <= user_paused_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      dim_level   <= dim_d;
      rgb_out     <= rgb_d;
    end
  end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Bench for pause_dim_ctrl: vector table, directed corner sequences and a randomized run,
// all checked against an arithmetic reference model.
module tb_pause_dim_ctrl;

  localparam int DT = 10;
  localparam int ST = 4;
  localparam int DM = 2;

  logic        clk_sys = 1'b0;
  logic        reset, pause_btn, osd_open, osd_pause_en, vblank;
  logic [1:0]  pause_req;
  logic [11:0] rgb_in;
  logic        pause, user_paused, pause_v, user_paused_v;
  logic [2:0]  dim_level, dim_level_v;
  logic [11:0] rgb_out, rgb_out_v;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk_sys = ~clk_sys;

  pause_dim_ctrl #(.NREQ(2), .COLW(4), .DIM_TICKS(DT), .STEP_TICKS(ST), .DIM_MAX(DM),
                   .SYNC_VBL(0), .CNTW(8)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .pause_btn(pause_btn), .pause_req(pause_req),
    .osd_open(osd_open), .osd_pause_en(osd_pause_en), .vblank(vblank), .rgb_in(rgb_in),
    .pause(pause), .user_paused(user_paused), .dim_level(dim_level), .rgb_out(rgb_out)
  );

  pause_dim_ctrl #(.NREQ(2), .COLW(4), .DIM_TICKS(DT), .STEP_TICKS(ST), .DIM_MAX(DM),
                   .SYNC_VBL(1), .CNTW(8)) u_dut_v (
    .clk_sys(clk_sys), .reset(reset), .pause_btn(pause_btn), .pause_req(pause_req),
    .osd_open(osd_open), .osd_pause_en(osd_pause_en), .vblank(vblank), .rgb_in(rgb_in),
    .pause(pause_v), .user_paused(user_paused_v), .dim_level(dim_level_v), .rgb_out(rgb_out_v)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Dim level after a user pause has been held for a edges.
  function automatic logic [2:0] dim_of(input int a);
    int v;
    if (a < DT) return 3'd0;
    v = 1 + (a - DT) / ST;
    if (v > DM) v = DM;
    return 3'(v);
  endfunction

  function automatic logic [11:0] shift_rgb(input logic [11:0] x, input logic [2:0] d);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*4 +: 4] = x[i*4 +: 4] >> d;
    return r;
  endfunction

  // Reference model
  logic        m_btn_prev, m_up, m_pause, m_ps, m_pause_v, m_vbl_prev;
  int          m_age;
  logic [2:0]  m_dim;
  logic [11:0] m_rgb;
  logic        m_osd, m_rise;

  assign m_osd  = osd_open & osd_pause_en;
  assign m_rise = vblank & ~m_vbl_prev;

  always @(posedge clk_sys) begin
    if (reset) begin
      m_btn_prev <= 1'b1;
      m_vbl_prev <= 1'b1;
      m_up       <= 1'b0;
      m_age      <= 0;
      m_dim      <= 3'd0;
      m_rgb      <= 12'h000;
      m_pause    <= 1'b0;
      m_ps       <= 1'b0;
      m_pause_v  <= 1'b0;
    end else begin
      m_btn_prev <= pause_btn;
      m_vbl_prev <= vblank;
      m_up       <= m_up ^ (pause_btn & ~m_btn_prev);
      m_age      <= m_up ? m_age + 1 : 0;
      m_dim      <= m_up ? dim_of(m_age + 1) : 3'd0;
      m_rgb      <= shift_rgb(rgb_in, m_dim);
      m_pause    <= (|pause_req) | m_up | m_osd;
      m_ps       <= m_rise ? (m_up | m_osd) : m_ps;
      m_pause_v  <= (|pause_req) | (m_rise ? (m_up | m_osd) : m_ps);
    end
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("model_pause", 32'(pause), 32'(m_pause));
      chk("model_user_paused", 32'(user_paused), 32'(m_up));
      chk("model_dim", 32'(dim_level), 32'(m_dim));
      chk("model_rgb", 32'(rgb_out), 32'(m_rgb));
      chk("model_pause_vbl", 32'(pause_v), 32'(m_pause_v));
      chk("model_dim_vbl", 32'(dim_level_v), 32'(m_dim));
    end
  end

  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        osd;
    logic        en;
    logic [11:0] rgb;
    logic        exp_pause;
    logic        exp_pause_v;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'b00, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0, 12'h123};
    vecs[1] = '{2'b01, 1'b0, 1'b0, 12'hABC, 1'b1, 1'b1, 12'hABC};
    vecs[2] = '{2'b10, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b1, 12'hFFF};
    vecs[3] = '{2'b00, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000};
    vecs[4] = '{2'b00, 1'b1, 1'b1, 12'h5A5, 1'b1, 1'b0, 12'h5A5};
    vecs[5] = '{2'b11, 1'b1, 1'b1, 12'hF0F, 1'b1, 1'b1, 12'hF0F};
    vecs[6] = '{2'b00, 1'b0, 1'b1, 12'h777, 1'b0, 1'b0, 12'h777};

    reset = 1'b1; pause_btn = 1'b0; pause_req = 2'b00; osd_open = 1'b0;
    osd_pause_en = 1'b0; vblank = 1'b0; rgb_in = 12'h000;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_pause", 32'(pause), 0);
    chk("reset_user_paused", 32'(user_paused), 0);
    chk("reset_dim", 32'(dim_level), 0);
    chk("reset_rgb", 32'(rgb_out), 0);
    reset = 1'b0;
    step();

    // Vector table: no user pause, no vblank edge, dim stays 0
    for (int i = 0; i < 7; i++) begin
      pause_req = vecs[i].req; osd_open = vecs[i].osd; osd_pause_en = vecs[i].en;
      rgb_in = vecs[i].rgb;
      step();
      chk($sformatf("vec%0d_pause", i), 32'(pause), 32'(vecs[i].exp_pause));
      chk($sformatf("vec%0d_pause_vbl", i), 32'(pause_v), 32'(vecs[i].exp_pause_v));
      chk($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
    end
    pause_req = 2'b00; osd_open = 1'b0; osd_pause_en = 1'b0;

    // Button held through reset does not toggle
    pause_btn = 1'b1; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    chk("held_btn_no_toggle", 32'(user_paused), 0);
    pause_btn = 1'b0;
    step();
    chk("release_no_toggle", 32'(user_paused), 0);
    rgb_in = 12'hFFF;
    pause_btn = 1'b1;
    step();
    chk("press_user_paused", 32'(user_paused), 1);
    chk("press_pause_lag", 32'(pause), 0);
    pause_btn = 1'b0;

    // Dim schedule: 1 at +10, 2 at +14, then held
    for (int k = 1; k <= 20; k++) begin
      step();
      case (k)
        1:  chk("press_pause", 32'(pause), 1);
        9:  chk("dim_k9", 32'(dim_level), 0);
        10: chk("dim_k10", 32'(dim_level), 1);
        11: chk("rgb_k11", 32'(rgb_out), 32'h777);
        13: chk("dim_k13", 32'(dim_level), 1);
        14: chk("dim_k14", 32'(dim_level), 2);
        15: chk("rgb_k15", 32'(rgb_out), 32'h333);
        20: chk("dim_k20_hold", 32'(dim_level), 2);
        default: ;
      endcase
    end
    pause_btn = 1'b1; step();
    pause_btn = 1'b0; step(); step();
    chk("unpause_dim", 32'(dim_level), 0);
    chk("unpause_user", 32'(user_paused), 0);

    // Unpause while fading
    pause_btn = 1'b1; step();
    pause_btn = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      case (k)
        11: pause_btn = 1'b1;
        12: begin
          chk("fade_unpause_user", 32'(user_paused), 0);
          chk("fade_unpause_dim_k12", 32'(dim_level), 1);
        end
        13: begin
          chk("fade_unpause_dim_k13", 32'(dim_level), 0);
          chk("fade_unpause_rgb_k13", 32'(rgb_out), 32'h777);
        end
        14: chk("fade_unpause_rgb_k14", 32'(rgb_out), 32'hFFF);
        default: ;
      endcase
    end
    pause_btn = 1'b0;
    step();

    // OSD pause never starts the dim; SYNC_VBL instance waits for vblank rise
    osd_open = 1'b1; osd_pause_en = 1'b0;
    repeat (2 * DT) step();
    chk("osd_noen_pause", 32'(pause), 0);
    chk("osd_noen_dim", 32'(dim_level), 0);
    osd_pause_en = 1'b1;
    step();
    chk("osd_en_pause", 32'(pause), 1);
    chk("osd_en_pause_vbl_wait", 32'(pause_v), 0);
    repeat (2 * DT) step();
    chk("osd_en_dim", 32'(dim_level), 0);
    chk("osd_en_pause_vbl_still", 32'(pause_v), 0);
    vblank = 1'b1;
    step();
    chk("vbl_rise_pause", 32'(pause_v), 1);
    vblank = 1'b0; osd_open = 1'b0;
    step(); step(); step();
    chk("osd_off_pause", 32'(pause), 0);
    chk("osd_off_vbl_hold", 32'(pause_v), 1);
    vblank = 1'b1;
    step();
    chk("vbl_rise_release", 32'(pause_v), 0);
    vblank = 1'b0;
    step(); step();
    pause_req = 2'b10;
    step();
    chk("req_pulse_pause", 32'(pause), 1);
    chk("req_pulse_pause_vbl", 32'(pause_v), 1);
    pause_req = 2'b00;
    step();
    chk("req_end_pause_vbl", 32'(pause_v), 0);
    osd_pause_en = 1'b0;

    // Reset while fading
    pause_btn = 1'b1; step();
    pause_btn = 1'b0;
    repeat (11) step();
    chk("pre_reset_dim", 32'(dim_level), 1);
    reset = 1'b1;
    step();
    chk("fade_reset_pause", 32'(pause), 0);
    chk("fade_reset_user", 32'(user_paused), 0);
    chk("fade_reset_dim", 32'(dim_level), 0);
    chk("fade_reset_rgb", 32'(rgb_out), 0);
    reset = 1'b0;
    step();

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) pause_btn = ~pause_btn;
      pause_req = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 49) == 0) osd_open = ~osd_open;
      if ($urandom_range(0, 49) == 0) osd_pause_en = ~osd_pause_en;
      vblank = ((i % 37) > 30);
      rgb_in = 12'($urandom);
      reset  = ($urandom_range(0, 599) == 0);
      step();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
